countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter with terminal-count detection and optional auto-reload. It is the count-down counterpart to the team's loadable up-counter and shares its control pins: load, output enable and count enable. Software loads a start value and enables counting. The block decrements once per enabled clock, then either stops at zero or reloads, and flags each expiry with a one-cycle pulse.

## Interface
- WIDTH, 8, counter and load-value width (minimum 2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  capture load_val into counter and reload register
- load_val  in  WIDTH  start/reload value
- count_en  in  1  decrement enable (1 = count down, 0 = hold)
- auto_reload  in  1  on expiry, reload from reload register instead of stopping at 0
- out_en  in  1  output enable for count (active high)
- count  out  WIDTH  current counter value when out_en=1, else all zeros (no tri-state)
- zero  out  1  level, counter register == 0; not gated by out_en
- tc_pulse  out  1  one-cycle pulse, counter expired at the last edge
- running  out  1  a decrement or reload-on-expiry occurred at the last edge
- expiries  out  4  saturating count of expiries since reset or last load

## Operation
- Internal registers: cnt[WIDTH], reload[WIDTH], tc_pulse, running, expiries[4].
- Priority at each rising edge: reset > load > count > hold.
- reset=1: cnt=0, reload=0, tc_pulse=0, running=0, expiries=0.
  - Resulting outputs: count=0, zero=1.
- load=1: cnt=load_val, reload=load_val, expiries=0, tc_pulse=0, running=0.
  - count_en is ignored on this edge.
- count_en=1, load=0, cnt>1: cnt=cnt-1, running=1, tc_pulse=0.
- count_en=1, load=0, cnt==1 is the expiry edge:
  - tc_pulse=1, running=1, expiries=min(expiries+1, 15).
  - auto_reload=0: cnt=0.
  - auto_reload=1: cnt=reload. If reload==0, cnt=0.
- count_en=1, load=0, cnt==0: no decrement and no wrap to all-ones. cnt holds, tc_pulse=0, running=0.
- count_en=0, load=0: cnt, reload and expiries hold; tc_pulse=0, running=0.
- auto_reload is sampled only on the expiry edge, so changing it mid-count is legal.
- Loading 0 leaves the block idle: zero=1, and no tc_pulse is ever produced.
- Arithmetic:
  - Unsigned, modulo-free; cnt never underflows.
  - expiries saturates at 15 and does not wrap.
- Phases, derived rather than an explicit state register:
  - IDLE: cnt==0.
  - ARMED: cnt>0, count_en=0.
  - RUN: cnt>0, count_en=1.
  - RUN -> IDLE on expiry without reload; RUN -> RUN on expiry with reload.

## Timing
- All outputs are registered except count and zero.
  - count is the combinational gate of cnt by out_en.
  - zero is the combinational compare of cnt.
- Load latency is 1 cycle: load_val is visible on count after the load edge.
- Loaded value V with count_en held high from the next edge: cnt reaches 0 V edges after the load edge.
- tc_pulse is high for exactly the cycle following the expiry edge. It coincides with zero=1, or with count=reload under auto_reload.
- With auto_reload=1 and V>0, tc_pulse repeats every V cycles. For V=1 it repeats every cycle (tc_pulse stuck high, count stays 1).
- load and expiry on the same edge: load wins, with no tc_pulse and no expiries increment.
- reset mid-count: all registers clear on that edge, and tc_pulse is not asserted.
- out_en affects only count, with no cycle delay. zero, tc_pulse and expiries are unaffected.

## Test plan
- Reset mid-run then load:
  - Stimulus: assert reset mid-run.
  - Required: next cycle count=0, zero=1, tc_pulse=0, running=0, expiries=0.
  - Stimulus: load 0x05.
  - Required: count=5, zero=0.
- One-shot countdown:
  - Stimulus: load 3, then count_en=1 with auto_reload=0.
  - Required: count goes 3,2,1,0 on successive cycles; tc_pulse=1 for exactly the cycle count first reads 0; expiries=1.
  - Stimulus: keep count_en high for a further 4 cycles.
  - Required: count stays 0 with no further pulses.
- Auto-reload:
  - Stimulus: load 4, auto_reload=1, count_en=1 for 12 cycles.
  - Required: count sequence 4,3,2,1,4,3,2,1,...; tc_pulse on every cycle where count returns to 4; expiries=3; zero never asserts.
- Hold and gating:
  - Stimulus: load 0xC8 and count 5 cycles (count=0xC3), then count_en=0 for 10 cycles.
  - Required: count holds 0xC3.
  - Stimulus: drop out_en.
  - Required: count=0 while zero=0 and the internal value is retained; restoring out_en shows 0xC3.
- Collisions:
  - Stimulus: load 0x10 on the same edge as an expiry from cnt=1.
  - Required: count=0x10, tc_pulse=0, expiries=0.
  - Stimulus: load 0.
  - Required: zero=1 and no tc_pulse ever.
- Saturation:
  - Stimulus: load 1 with auto_reload=1, count_en=1 for 20 cycles.
  - Required: tc_pulse high for all 20 cycles; expiries stops at 15; count stays 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: software-side controls in,
// counter view and expiry status out.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             count_en;
    logic             auto_reload;
    logic             out_en;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc_pulse;
    logic             running;
    logic [3:0]       expiries;

    modport master (
        output load, load_val, count_en, auto_reload, out_en,
        input  count, zero, tc_pulse, running, expiries
    );

    modport slave (
        input  load, load_val, count_en, auto_reload, out_en,
        output count, zero, tc_pulse, running, expiries
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter that stops at zero or auto-reloads on expiry,
// flagging each expiry with a one-cycle pulse and a saturating tally.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc_pulse;
    logic             r_running;
    logic [3:0]       r_expiries;

    logic             w_expire;
    logic             w_decrement;

    // cnt==0 falls into neither case, so the counter can never underflow.
    assign w_expire    = bus.count_en && (r_cnt == WIDTH'(1));
    assign w_decrement = bus.count_en && (r_cnt >  WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_reload   <= '0;
            r_tc_pulse <= 1'b0;
            r_running  <= 1'b0;
            r_expiries <= '0;
        end else if (bus.load) begin
            r_cnt      <= bus.load_val;
            r_reload   <= bus.load_val;
            r_tc_pulse <= 1'b0;
            r_running  <= 1'b0;
            r_expiries <= '0;
        end else if (w_expire) begin
            // A zero reload value lands on 0 naturally, leaving the block idle.
            r_cnt      <= bus.auto_reload ? r_reload : '0;
            r_tc_pulse <= 1'b1;
            r_running  <= 1'b1;
            if (r_expiries != 4'hF)
                r_expiries <= r_expiries + 4'd1;
        end else if (w_decrement) begin
            r_cnt      <= r_cnt - WIDTH'(1);
            r_tc_pulse <= 1'b0;
            r_running  <= 1'b1;
        end else begin
            r_tc_pulse <= 1'b0;
            r_running  <= 1'b0;
        end
    end

    assign bus.count    = bus.out_en ? r_cnt : '0;
    assign bus.zero     = (r_cnt == '0);
    assign bus.tc_pulse = r_tc_pulse;
    assign bus.running  = r_running;
    assign bus.expiries = r_expiries;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the timer.
module tb_countdown_timer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   ncmp  = 0;
    int   nfail = 0;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain integers updated from the operating rules.
    int m_cnt = 0, m_rel = 0, m_exp = 0;
    bit m_tc = 0, m_run = 0;

    function automatic logic [14:0] exp_vec();
        logic [7:0] c;
        c = bus.out_en ? 8'(m_cnt) : 8'h00;
        return {c, (m_cnt == 0), m_tc, m_run, 4'(m_exp)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.count, bus.zero, bus.tc_pulse, bus.running, bus.expiries};
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_exp = 0; m_tc = 0; m_run = 0;
        end else if (bus.load) begin
            m_cnt = int'(bus.load_val); m_rel = m_cnt; m_exp = 0; m_tc = 0; m_run = 0;
        end else if (bus.count_en && m_cnt > 0) begin
            m_run = 1;
            if (m_cnt == 1) begin
                m_tc  = 1;
                m_exp = (m_exp >= 15) ? 15 : m_exp + 1;
                m_cnt = bus.auto_reload ? m_rel : 0;
            end else begin
                m_tc  = 0;
                m_cnt = m_cnt - 1;
            end
        end else begin
            m_tc = 0; m_run = 0;
        end
    endtask

    // Advance one edge; inputs change only #1 after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(bit ld, int v, bit ce, bit ar, bit oe);
        bus.load        = ld;
        bus.load_val    = 8'(v);
        bus.count_en    = ce;
        bus.auto_reload = ar;
        bus.out_en      = oe;
    endtask

    task automatic test_reset();
        reset = 1'b1; drive(0, 0, 0, 0, 1);
        tick(); tick();
        reset = 1'b0;
        drive(1, 9, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 1); tick(); tick();
        reset = 1'b1; drive(0, 0, 0, 0, 1); tick();
        reset = 1'b0;
        ncmp++;
        if ({bus.count, bus.zero, bus.tc_pulse, bus.running, bus.expiries} !== {8'h00, 1'b1, 1'b0, 1'b0, 4'h0}) begin
            nfail++; $display("FAIL reset_state got=%h want=%h", dut_vec(), {8'h00, 4'b1000, 3'b000});
        end
        drive(1, 5, 0, 0, 1); tick();
        ncmp++;
        if ({bus.count, bus.zero} !== {8'h05, 1'b0}) begin
            nfail++; $display("FAIL reset_then_load got count=%h zero=%b want 05/0", bus.count, bus.zero);
        end
    endtask

    task automatic test_oneshot();
        int ec[7] = '{2, 1, 0, 0, 0, 0, 0};
        bit et[7] = '{0, 0, 1, 0, 0, 0, 0};
        drive(1, 3, 0, 0, 1); tick();
        ncmp++;
        if (bus.count !== 8'd3) begin nfail++; $display("FAIL oneshot_load got=%0d want=3", bus.count); end
        drive(0, 0, 1, 0, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            ncmp++;
            if ({bus.count, bus.tc_pulse} !== {8'(ec[k]), et[k]} || dut_vec() !== exp_vec()) begin
                nfail++; $display("FAIL oneshot_step%0d got count=%0d tc=%b want count=%0d tc=%b", k, bus.count, bus.tc_pulse, ec[k], et[k]);
            end
        end
        ncmp++;
        if (bus.expiries !== 4'd1) begin nfail++; $display("FAIL oneshot_expiries got=%0d want=1", bus.expiries); end
    endtask

    task automatic test_autoreload();
        int ec;
        drive(1, 4, 0, 1, 1); tick();
        drive(0, 0, 1, 1, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            ec = (k % 4 == 0) ? 4 : 4 - (k % 4);
            ncmp++;
            if ({bus.count, bus.tc_pulse, bus.zero} !== {8'(ec), (k % 4 == 0), 1'b0}) begin
                nfail++; $display("FAIL autoreload_step%0d got count=%0d tc=%b zero=%b want count=%0d tc=%b zero=0", k, bus.count, bus.tc_pulse, bus.zero, ec, (k % 4 == 0));
            end
        end
        ncmp++;
        if (bus.expiries !== 4'd3) begin nfail++; $display("FAIL autoreload_expiries got=%0d want=3", bus.expiries); end
    endtask

    task automatic test_hold_gate();
        drive(1, 8'hC8, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 1);
        repeat (5) tick();
        ncmp++;
        if (bus.count !== 8'hC3) begin nfail++; $display("FAIL hold_after_count got=%h want=c3", bus.count); end
        drive(0, 0, 0, 0, 1);
        repeat (10) tick();
        ncmp++;
        if ({bus.count, bus.running, bus.tc_pulse} !== {8'hC3, 2'b00}) begin
            nfail++; $display("FAIL hold_count got=%h run=%b tc=%b want=c3/0/0", bus.count, bus.running, bus.tc_pulse);
        end
        bus.out_en = 1'b0; #1;
        ncmp++;
        if ({bus.count, bus.zero} !== {8'h00, 1'b0}) begin
            nfail++; $display("FAIL gate_off got count=%h zero=%b want 00/0", bus.count, bus.zero);
        end
        tick();
        bus.out_en = 1'b1; #1;
        ncmp++;
        if (bus.count !== 8'hC3) begin nfail++; $display("FAIL gate_restore got=%h want=c3", bus.count); end
    endtask

    task automatic test_collision();
        drive(1, 2, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 1); tick();
        drive(1, 8'h10, 1, 0, 1); tick();
        ncmp++;
        if ({bus.count, bus.tc_pulse, bus.expiries} !== {8'h10, 1'b0, 4'h0}) begin
            nfail++; $display("FAIL collision got count=%h tc=%b exp=%0d want 10/0/0", bus.count, bus.tc_pulse, bus.expiries);
        end
        drive(1, 0, 0, 1, 1); tick();
        drive(0, 0, 1, 1, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            ncmp++;
            if ({bus.zero, bus.tc_pulse, bus.count} !== {1'b1, 1'b0, 8'h00}) begin
                nfail++; $display("FAIL load_zero_step%0d got zero=%b tc=%b count=%h want 1/0/00", k, bus.zero, bus.tc_pulse, bus.count);
            end
        end
    endtask

    task automatic test_saturation();
        int ee;
        drive(1, 1, 0, 1, 1); tick();
        drive(0, 0, 1, 1, 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            ee = (k > 15) ? 15 : k;
            ncmp++;
            if ({bus.count, bus.tc_pulse, bus.expiries} !== {8'd1, 1'b1, 4'(ee)}) begin
                nfail++; $display("FAIL saturation_step%0d got count=%0d tc=%b exp=%0d want 1/1/%0d", k, bus.count, bus.tc_pulse, bus.expiries, ee);
            end
        end
    endtask

    task automatic test_random();
        int v;
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(99) < 2);
            v = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(4);
            drive(($urandom_range(99) < 10), v, ($urandom_range(99) < 80),
                  $urandom_range(1), ($urandom_range(99) < 85));
            tick();
            ncmp++;
            if (dut_vec() !== exp_vec()) begin
                nfail++; $display("FAIL random_step%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        test_reset();
        test_oneshot();
        test_autoreload();
        test_hold_gate();
        test_collision();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
